// File: rtl/seq_det_pkg.sv
// Shared constants for the parametrised serial pattern detector.
package seq_det_pkg;
  localparam int MODE_NONOVERLAP = 0;
  localparam int MODE_OVERLAP    = 1;
  localparam int MAX_PATTERN_LEN = 32;
endpackage

// File: rtl/seq_window.sv
// Serial history window: shift register of the last PATTERN_LEN-1 valid bits
// plus a saturating fill counter that says when a full compare window exists.
module seq_window import seq_det_pkg::*; #(
  parameter int PATTERN_LEN = 4,
  parameter int OVERLAP     = MODE_OVERLAP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  input  logic                   data_i,
  input  logic                   load_i,
  input  logic                   match_i,
  output logic [PATTERN_LEN-1:0] window_o,
  output logic                   armed_o
);
  localparam int FILL_W = $clog2(PATTERN_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_LEN - 1);

  logic [PATTERN_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]      fill_q, fill_d;

  assign window_o = {hist_q, data_i};
  assign armed_o  = (fill_q == FILL_MAX);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    // A load drops the same-cycle bit and restarts the fill count.
    if (load_i) begin
      fill_d = '0;
    end else if (valid_i) begin
      hist_d = window_o[PATTERN_LEN-2:0];
      if (match_i && OVERLAP == MODE_NONOVERLAP) fill_d = '0;
      else if (!armed_o)                         fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end
endmodule

// File: rtl/seq_detector_param.sv
// Parametrised MSB-first serial pattern detector with reloadable pattern,
// registered match pulse and saturating match counter.
module seq_detector_param import seq_det_pkg::*; #(
  parameter int                     PATTERN_LEN   = 4,
  parameter logic [PATTERN_LEN-1:0] RESET_PATTERN = 4'b1010,
  parameter int                     OVERLAP       = MODE_OVERLAP,
  parameter int                     CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   data,
  input  logic                   pat_load,
  input  logic [PATTERN_LEN-1:0] pat_in,
  output logic                   detected,
  output logic [CNT_W-1:0]       match_count,
  output logic                   count_sat
);
  if (PATTERN_LEN < 2 || PATTERN_LEN > MAX_PATTERN_LEN || CNT_W < 1) begin : g_bad_cfg
    $error("seq_detector_param: illegal PATTERN_LEN=%0d or CNT_W=%0d", PATTERN_LEN, CNT_W);
  end

  logic [PATTERN_LEN-1:0] pat_q, pat_d;
  logic                   det_q, det_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sat_q, sat_d;
  logic [PATTERN_LEN-1:0] window;
  logic                   armed;
  logic                   match;

  seq_window #(
    .PATTERN_LEN (PATTERN_LEN),
    .OVERLAP     (OVERLAP)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (in_valid),
    .data_i   (data),
    .load_i   (pat_load),
    .match_i  (match),
    .window_o (window),
    .armed_o  (armed)
  );

  // Mealy decision on the bit being sampled this cycle; load wins over data.
  assign match = in_valid && !pat_load && armed && (window == pat_q);

  always_comb begin
    pat_d = pat_load ? pat_in : pat_q;
    det_d = match;
    cnt_d = cnt_q;
    if (match && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    sat_d = sat_q || (&cnt_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= RESET_PATTERN;
      det_q <= 1'b0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      pat_q <= pat_d;
      det_q <= det_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign detected    = det_q;
  assign match_count = cnt_q;
  assign count_sat   = sat_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: overlapping, non-overlapping and 2-bit-counter detectors
// driven by a common stimulus stream.
module tb_seq_detector_param;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       data = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;

  logic       det_a, sat_a, det_b, sat_b, det_c, sat_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PATTERN_LEN(4), .RESET_PATTERN(4'b1010), .OVERLAP(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data(data), .pat_load(pat_load),
    .pat_in(pat_in), .detected(det_a), .match_count(cnt_a), .count_sat(sat_a));
  seq_detector_param #(.PATTERN_LEN(4), .RESET_PATTERN(4'b1010), .OVERLAP(0), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data(data), .pat_load(pat_load),
    .pat_in(pat_in), .detected(det_b), .match_count(cnt_b), .count_sat(sat_b));
  seq_detector_param #(.PATTERN_LEN(4), .RESET_PATTERN(4'b1010), .OVERLAP(1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data(data), .pat_load(pat_load),
    .pat_in(pat_in), .detected(det_c), .match_count(cnt_c), .count_sat(sat_c));

  typedef struct {
    logic       rst, vld, dat, ld;
    logic [3:0] pat;
    logic       det;
    logic [7:0] cnt;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic d, input logic l,
                     input logic [3:0] p, input logic e_det, input logic [7:0] e_cnt);
    vec_t t;
    t.rst = r; t.vld = v; t.dat = d; t.ld = l; t.pat = p; t.det = e_det; t.cnt = e_cnt;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic d, input logic l, input logic [3:0] p);
    rst = r; in_valid = v; data = d; pat_load = l; pat_in = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Test 1: overlapping, 101010
    add(0,1,1,0,0, 0, 0); add(0,1,0,0,0, 0, 0); add(0,1,1,0,0, 0, 0);
    add(0,1,0,0,0, 1, 1); add(0,1,1,0,0, 0, 1); add(0,1,0,0,0, 1, 2);
    add(1,0,0,0,0, 0, 0);
    // Test 3: gap of 3 invalid cycles does not break the partial sequence
    add(0,1,1,0,0, 0, 0); add(0,1,0,0,0, 0, 0);
    add(0,0,1,0,0, 0, 0); add(0,0,0,0,0, 0, 0); add(0,0,1,0,0, 0, 0);
    add(0,1,1,0,0, 0, 0); add(0,1,0,0,0, 1, 1);
    add(1,0,0,0,0, 0, 0);
    // Test 4: reload to 0110 mid-sequence; the valid bit with the load is dropped
    add(0,1,1,0,0, 0, 0); add(0,1,0,0,0, 0, 0); add(0,1,1,0,0, 0, 0);
    add(0,1,1,1,4'b0110, 0, 0);
    add(0,1,0,0,0, 0, 0); add(0,1,1,0,0, 0, 0); add(0,1,1,0,0, 0, 0); add(0,1,0,0,0, 1, 1);
    add(0,1,1,0,0, 0, 1); add(0,1,0,0,0, 0, 1); add(0,1,1,0,0, 0, 1); add(0,1,0,0,0, 0, 1);
    // Test 5: reset discards partial sequence and restores 1010
    add(0,1,1,0,0, 0, 1); add(0,1,0,0,0, 0, 1); add(0,1,1,0,0, 0, 1);
    add(1,0,0,0,0, 0, 0);
    add(0,1,0,0,0, 0, 0);

    step(1,0,0,0,0);
    step(1,0,0,0,0);
    chk("reset det_a", det_a, 0); chk("reset cnt_a", cnt_a, 0); chk("reset sat_a", sat_a, 0);
    chk("reset det_b", det_b, 0); chk("reset cnt_b", cnt_b, 0);
    chk("reset cnt_c", cnt_c, 0); chk("reset sat_c", sat_c, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].vld, vecs[i].dat, vecs[i].ld, vecs[i].pat);
      chk($sformatf("vec%0d det", i), det_a, vecs[i].det);
      chk($sformatf("vec%0d cnt", i), cnt_a, vecs[i].cnt);
    end

    // Test 2: non-overlapping vs overlapping on 10101010
    step(1,0,0,0,0);
    for (int i = 0; i < 8; i++) begin
      step(0,1,(i % 2 == 0),0,0);
      chk($sformatf("novl bit%0d det_b", i+1), det_b, (i == 3 || i == 7));
      chk($sformatf("ovl bit%0d det_a", i+1), det_a, (i >= 3 && i % 2 == 1));
    end
    chk("novl cnt_b", cnt_b, 2);
    chk("ovl cnt_a", cnt_a, 3);
    chk("novl sat_b", sat_b, 0);

    // Test 6: 2-bit counter saturates at the 3rd of 7 matches
    step(1,0,0,0,0);
    for (int i = 0; i < 16; i++) begin
      int m;
      step(0,1,(i % 2 == 0),0,0);
      m = (i >= 3) ? (i - 1) / 2 : 0;
      chk($sformatf("sat bit%0d det_c", i+1), det_c, (i >= 3 && i % 2 == 1));
      chk($sformatf("sat bit%0d cnt_c", i+1), cnt_c, (m > 3) ? 3 : m);
      chk($sformatf("sat bit%0d sat_c", i+1), sat_c, (m >= 3));
    end

    // Reset clears the sticky saturation flag
    step(1,0,0,0,0);
    chk("post-rst sat_c", sat_c, 0);
    chk("post-rst cnt_c", cnt_c, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
